// File: rtl/param_seq_detector_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// Optional registered match output is selected with SEQDET_REG_OUT_EN.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

  // Low 'len' bits set; lengths of 32 or more give an all-ones mask.
  function automatic logic [31:0] len_mask(input logic [31:0] len);
    if (len >= 32'd32) return '1;
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/param_seq_detector_if.sv
// Config, serial data and status bundle between a bit producer and the detector.
interface param_seq_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               armed;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    input  match, match_count, cfg_err, armed
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    output match, match_count, cfg_err, armed
  );
endinterface

// File: rtl/param_seq_detector_cmp.sv
// Masked comparator: hit when the low len_i bits of cand_i equal those of pattern_i.
module seq_det_cmp
  import seq_det_pkg::*;
#(
  parameter int W  = 8,
  parameter int LW = 4
) (
  input  logic [W-1:0]  cand_i,
  input  logic [W-1:0]  pattern_i,
  input  logic [LW-1:0] len_i,
  output logic          hit_o
);
  logic [31:0] mask;

  always_comb mask = len_mask(32'(len_i));

  assign hit_o = (((32'(cand_i) ^ 32'(pattern_i)) & mask) == 32'd0);
endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial sequence detector with overlap control and saturating match count.
// Define SEQDET_REG_OUT_EN to register match one cycle after the completing bit.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input logic                 clk,
  input logic                 reset,
  param_seq_detector_if.slave bus
);
  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  state_e             state_q;
  logic [MAX_LEN-2:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] pat_q;
  logic               ovl_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
`ifdef SEQDET_REG_OUT_EN
  logic               match_q;
`endif

  logic [MAX_LEN-1:0] cand_d;
  logic [LEN_W-1:0]   fill_d;
  logic               sample;
  logic               cmp_hit;
  logic               hit;
  logic               cfg_bad;

  assign cand_d  = {hist_q, bus.din};
  assign fill_d  = (fill_q == MAXL) ? fill_q : fill_q + ONE;
  assign sample  = bus.din_valid && !bus.cfg_load && (state_q != IDLE);
  assign hit     = sample && (state_q == ARMED) && cmp_hit;
  assign cfg_bad = (bus.cfg_len == '0) || (bus.cfg_len > MAXL);

  seq_det_cmp #(.W(MAX_LEN), .LW(LEN_W)) u_cmp (
    .cand_i    (cand_d),
    .pattern_i (pat_q),
    .len_i     (len_q),
    .hit_o     (cmp_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef SEQDET_REG_OUT_EN
      match_q <= 1'b0;
`endif
    end else if (bus.cfg_load) begin
      // A new config always restarts the search; a coincident data bit is dropped.
      pat_q   <= bus.cfg_pattern;
      len_q   <= bus.cfg_len;
      ovl_q   <= bus.cfg_overlap;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      err_q   <= cfg_bad;
`ifdef SEQDET_REG_OUT_EN
      match_q <= 1'b0;
`endif
      if (cfg_bad)                  state_q <= IDLE;
      else if (bus.cfg_len == ONE)  state_q <= ARMED;
      else                          state_q <= FILL;
    end else begin
`ifdef SEQDET_REG_OUT_EN
      match_q <= hit;
`endif
      if (sample) begin
        if (hit && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        if (hit && !ovl_q) begin
          hist_q  <= '0;
          fill_q  <= '0;
          state_q <= (len_q == ONE) ? ARMED : FILL;
        end else begin
          hist_q <= cand_d[MAX_LEN-2:0];
          fill_q <= fill_d;
          if (fill_d >= len_q - ONE) state_q <= ARMED;
        end
      end
    end
  end

`ifdef SEQDET_REG_OUT_EN
  assign bus.match = match_q;
`else
  assign bus.match = hit;
`endif
  assign bus.match_count = cnt_q;
  assign bus.cfg_err     = err_q;
  assign bus.armed       = (state_q == ARMED);
endmodule

// File: tb/tb_param_seq_detector.sv
// Directed and randomized checks of param_seq_detector against a queue-based reference model.
module tb_param_seq_detector;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_seq_detector_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  param_seq_detector #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the sampled bits since the last restart, oldest first.
  bit          q[$];
  int          m_len;
  logic [31:0] m_pat;
  bit          m_ovl;
  bit          m_err;
  bit          m_ok;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // The newest bit lines up with pattern bit 0, the one before with bit 1, and so on.
  function automatic bit model_hit(input bit d);
    bit b;
    if (!m_ok || q.size() < m_len - 1) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      b = (j == 0) ? d : q[q.size() - j];
      if (b != m_pat[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit model_armed();
    return m_ok && (q.size() >= m_len - 1);
  endfunction

  task automatic check_status(input string tag);
    chk({tag, "_cnt"}, 32'(bus.match_count), m_cnt);
    chk({tag, "_armed"}, 32'(bus.armed), 32'(model_armed()));
    chk({tag, "_err"}, 32'(bus.cfg_err), 32'(m_err));
  endtask

  task automatic step(input bit v, input bit d, input string tag);
    bit h;
    bus.cfg_load  = 1'b0;
    bus.din_valid = v;
    bus.din       = d;
    #1;
    h = v && model_hit(d);
`ifndef SEQDET_REG_OUT_EN
    chk({tag, "_match"}, 32'(bus.match), 32'(h));
`endif
    @(posedge clk);
    #1;
    if (v && m_ok) begin
      if (h) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_ovl) q.push_back(d);
        else q.delete();
      end else begin
        q.push_back(d);
      end
      if (q.size() > MAX_LEN) void'(q.pop_front());
    end
`ifdef SEQDET_REG_OUT_EN
    chk({tag, "_match"}, 32'(bus.match), 32'(h));
`endif
    check_status(tag);
  endtask

  task automatic load(input logic [31:0] pat, input int len, input bit ovl);
    logic [31:0] lv;
    lv = 32'(len);
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = pat[MAX_LEN-1:0];
    bus.cfg_len     = lv[LEN_W-1:0];
    bus.cfg_overlap = ovl;
    bus.din_valid   = 1'b1;
    bus.din         = 1'($urandom_range(0, 1));
    #1;
`ifndef SEQDET_REG_OUT_EN
    chk("load_match", 32'(bus.match), 32'd0);
`endif
    @(posedge clk);
    #1;
    m_len = len;
    m_pat = pat;
    m_ovl = ovl;
    m_err = (len == 0) || (len > MAX_LEN);
    m_ok  = !m_err;
    m_cnt = 0;
    q.delete();
    bus.cfg_load  = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    chk("load_match_after", 32'(bus.match), 32'd0);
    check_status("load");
  endtask

  task automatic play(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], tag);
  endtask

  initial begin
    bit v;
    m_len = 0; m_pat = '0; m_ovl = 1'b0; m_err = 1'b0; m_ok = 1'b0; m_cnt = 0;
    bus.cfg_load = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
    bus.din_valid = 1'b0; bus.din = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_match", 32'(bus.match), 32'd0);
    check_status("rst");
    #12 reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, "idle");

    // 10101 overlapping: hits on bits 5 and 7
    load(32'b10101, 5, 1'b1);
    play(32'b1010101, 7, "ovl");
    chk("ovl_total", 32'(bus.match_count), 32'd2);

    // Same stream non-overlapping: only bit 5
    load(32'b10101, 5, 1'b0);
    play(32'b1010101, 7, "novl");
    chk("novl_total", 32'(bus.match_count), 32'd1);

    // 110 with idle gaps between valid bits
    load(32'b110, 3, 1'b1);
    step(1'b1, 1'b1, "gap"); step(1'b0, 1'b0, "gap"); step(1'b0, 1'b1, "gap");
    step(1'b1, 1'b1, "gap"); step(1'b0, 1'b0, "gap");
    step(1'b1, 1'b0, "gap"); step(1'b0, 1'b0, "gap");
    chk("gap_total", 32'(bus.match_count), 32'd1);

    // Illegal lengths
    load(32'hFF, 0, 1'b1);
    chk("len0_err", 32'(bus.cfg_err), 32'd1);
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, "len0");
    load(32'hFF, MAX_LEN + 1, 1'b1);
    chk("lenbig_err", 32'(bus.cfg_err), 32'd1);
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, "lenbig");
    chk("lenbig_total", 32'(bus.match_count), 32'd0);
    load(32'b11, 2, 1'b1);
    chk("len2_err", 32'(bus.cfg_err), 32'd0);
    play(32'b111, 3, "len2");

    // Length 1, saturation, then async reset mid-stream
    load(32'b1, 1, 1'b1);
    chk("len1_armed", 32'(bus.armed), 32'd1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, "sat");
    chk("sat_total", 32'(bus.match_count), 32'(CNT_MAX));
    bus.din_valid = 1'b1;
    bus.din       = 1'b1;
    #2 reset = 1'b1;
    #1;
    m_ok = 1'b0; m_err = 1'b0; m_cnt = 0; m_len = 0; q.delete();
    chk("arst_cnt", 32'(bus.match_count), 32'd0);
    chk("arst_match", 32'(bus.match), 32'd0);
    chk("arst_armed", 32'(bus.armed), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, "post_rst");

    // Randomized configs and streams
    for (int r = 0; r < 8; r++) begin
      load(32'($urandom_range(0, 255)), (r < 5) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, MAX_LEN)),
           1'($urandom_range(0, 1)));
      for (int i = 0; i < 60; i++) begin
        v = ($urandom_range(0, 3) != 0);
        step(v, 1'($urandom_range(0, 1)), "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
